// File: rtl/cci_test_rd_stream.sv
// Sequential-read traffic engine: issues num_lines channel-0 line reads from a
// virtual base address, checks that responses return in order with the expected
// tag and payload, and reports completion, error and cycle statistics.
module cci_test_rd_stream #(
   parameter int unsigned MAX_OUTSTANDING = 64,
   parameter int unsigned LINE_ADDR_WIDTH = 42,
   parameter int unsigned CNT_WIDTH       = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [LINE_ADDR_WIDTH-1:0] base_line_addr,
   input  logic [CNT_WIDTH-1:0]       num_lines,
   input  logic                       c0_tx_almost_full,
   output logic                       c0_req_valid,
   output logic [LINE_ADDR_WIDTH-1:0] c0_req_addr,
   output logic [15:0]                c0_req_mdata,
   input  logic                       c0_rsp_valid,
   input  logic [15:0]                c0_rsp_mdata,
   input  logic [511:0]               c0_rsp_data,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   output logic [CNT_WIDTH-1:0]       first_err_idx,
   output logic [CNT_WIDTH-1:0]       rsp_count,
   output logic [CNT_WIDTH-1:0]       cycle_count
);

   // One extra bit so the counter can represent MAX_OUTSTANDING itself.
   localparam int unsigned OutW = $clog2(MAX_OUTSTANDING) + 1;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e                     state_q, state_d;
   logic [LINE_ADDR_WIDTH-1:0] base_q, base_d;
   logic [CNT_WIDTH-1:0]       nlines_q, nlines_d;
   logic [CNT_WIDTH-1:0]       issued_q, issued_d;
   logic [CNT_WIDTH-1:0]       rcvd_q, rcvd_d;
   logic [OutW-1:0]            outst_q, outst_d;
   logic                       req_valid_q, req_valid_d;
   logic [LINE_ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
   logic [15:0]                req_mdata_q, req_mdata_d;
   logic                       err_q, err_d;
   logic [CNT_WIDTH-1:0]       first_err_idx_q, first_err_idx_d;
   logic [CNT_WIDTH-1:0]       rsp_count_q, rsp_count_d;
   logic [CNT_WIDTH-1:0]       cycle_count_q, cycle_count_d;
   logic                       active, issue, accept;

   assign active = (state_q == StRun) || (state_q == StDrain);

   // Next-state: FSM, request issue, response checking and counters.
   always_comb begin
      state_d         = state_q;
      base_d          = base_q;
      nlines_d        = nlines_q;
      issued_d        = issued_q;
      rcvd_d          = rcvd_q;
      outst_d         = outst_q;
      req_valid_d     = 1'b0;
      req_addr_d      = req_addr_q;
      req_mdata_d     = req_mdata_q;
      err_d           = err_q;
      first_err_idx_d = first_err_idx_q;
      rsp_count_d     = rsp_count_q;
      cycle_count_d   = cycle_count_q;
      issue           = 1'b0;
      accept          = 1'b0;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               base_d          = base_line_addr;
               nlines_d        = num_lines;
               issued_d        = '0;
               rcvd_d          = '0;
               outst_d         = '0;
               err_d           = 1'b0;
               first_err_idx_d = '0;
               rsp_count_d     = '0;
               cycle_count_d   = '0;
               // A zero-length run skips issue and completes via DRAIN.
               state_d         = (num_lines == '0) ? StDrain : StRun;
            end
         end
         StRun: begin
            if (!c0_tx_almost_full && (outst_q < OutW'(MAX_OUTSTANDING)) &&
                (issued_q < nlines_q)) begin
               issue       = 1'b1;
               req_valid_d = 1'b1;
               req_addr_d  = base_q + LINE_ADDR_WIDTH'(issued_q);
               req_mdata_d = issued_q[15:0];
               issued_d    = issued_q + CNT_WIDTH'(1);
            end
            if (issued_d == nlines_q) state_d = StDrain;
         end
         StDrain: begin
            if (rcvd_q == nlines_q) state_d = StDone;
         end
         default: state_d = StIdle;
      endcase

      if (active && c0_rsp_valid) begin
         if (outst_q == '0) begin
            // Unsolicited response: flag it but do not count it.
            if (!err_q) begin
               err_d           = 1'b1;
               first_err_idx_d = rcvd_q;
            end
         end else begin
            accept      = 1'b1;
            rcvd_d      = rcvd_q + CNT_WIDTH'(1);
            rsp_count_d = rsp_count_q + CNT_WIDTH'(1);
            if (!err_q && ((c0_rsp_mdata != rcvd_q[15:0]) ||
                           (c0_rsp_data[63:0] != 64'(rcvd_q)))) begin
               err_d           = 1'b1;
               first_err_idx_d = rcvd_q;
            end
         end
      end

      if (issue && !accept)      outst_d = outst_q + OutW'(1);
      else if (!issue && accept) outst_d = outst_q - OutW'(1);

      if (active && (cycle_count_q != '1)) cycle_count_d = cycle_count_q + CNT_WIDTH'(1);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= StIdle;
         base_q          <= '0;
         nlines_q        <= '0;
         issued_q        <= '0;
         rcvd_q          <= '0;
         outst_q         <= '0;
         req_valid_q     <= 1'b0;
         req_addr_q      <= '0;
         req_mdata_q     <= '0;
         err_q           <= 1'b0;
         first_err_idx_q <= '0;
         rsp_count_q     <= '0;
         cycle_count_q   <= '0;
      end else begin
         state_q         <= state_d;
         base_q          <= base_d;
         nlines_q        <= nlines_d;
         issued_q        <= issued_d;
         rcvd_q          <= rcvd_d;
         outst_q         <= outst_d;
         req_valid_q     <= req_valid_d;
         req_addr_q      <= req_addr_d;
         req_mdata_q     <= req_mdata_d;
         err_q           <= err_d;
         first_err_idx_q <= first_err_idx_d;
         rsp_count_q     <= rsp_count_d;
         cycle_count_q   <= cycle_count_d;
      end
   end

   assign c0_req_valid  = req_valid_q;
   assign c0_req_addr   = req_addr_q;
   assign c0_req_mdata  = req_mdata_q;
   assign busy          = active;
   assign done          = (state_q == StDone);
   assign err           = err_q;
   assign first_err_idx = first_err_idx_q;
   assign rsp_count     = rsp_count_q;
   assign cycle_count   = cycle_count_q;

endmodule
